// File: rtl/lcd_pkg.sv
// Shared LCD definitions: command opcodes, sequencer state encoding and the
// power-up command/data table used by the init sequencer.
package lcd_pkg;

   localparam logic [7:0] CMD_SWRESET    = 8'h01;
   localparam logic [7:0] CMD_SLPOUT     = 8'h11;
   localparam logic [7:0] CMD_COLMOD     = 8'h3A;
   localparam logic [7:0] CMD_MADCTL     = 8'h36;
   localparam logic [7:0] CMD_INVON      = 8'h21;
   localparam logic [7:0] CMD_NORON      = 8'h13;
   localparam logic [7:0] CMD_DISPON     = 8'h29;
   localparam logic [7:0] CMD_SET_COLUMN = 8'h2A;
   localparam logic [7:0] CMD_SET_PAGE   = 8'h2B;
   localparam logic [7:0] CMD_WRITE_RAM  = 8'h2C;

   localparam int unsigned CNT_W    = 22;
   localparam logic [3:0]  SEQ_LAST = 4'd8;

   typedef struct packed {
      logic       dc;
      logic [7:0] byte_val;
      logic       delay_after;
   } seq_entry_t;

   typedef enum logic [2:0] {
      StIdle, StHwrstLow, StHwrstWait, StLoad, StSend, StDelay, StDone
   } state_e;

   function automatic seq_entry_t seq_entry(input logic [3:0] idx,
                                            input logic [7:0] colmod_val,
                                            input logic [7:0] madctl_val);
      seq_entry_t e;
      e = '{dc: 1'b0, byte_val: 8'h00, delay_after: 1'b0};
      case (idx)
         4'd0:    e = '{dc: 1'b0, byte_val: CMD_SWRESET, delay_after: 1'b1};
         4'd1:    e = '{dc: 1'b0, byte_val: CMD_SLPOUT,  delay_after: 1'b1};
         4'd2:    e = '{dc: 1'b0, byte_val: CMD_COLMOD,  delay_after: 1'b0};
         4'd3:    e = '{dc: 1'b1, byte_val: colmod_val,  delay_after: 1'b0};
         4'd4:    e = '{dc: 1'b0, byte_val: CMD_MADCTL,  delay_after: 1'b0};
         4'd5:    e = '{dc: 1'b1, byte_val: madctl_val,  delay_after: 1'b0};
         4'd6:    e = '{dc: 1'b0, byte_val: CMD_INVON,   delay_after: 1'b0};
         4'd7:    e = '{dc: 1'b0, byte_val: CMD_NORON,   delay_after: 1'b0};
         4'd8:    e = '{dc: 1'b0, byte_val: CMD_DISPON,  delay_after: 1'b1};
         default: e = '{dc: 1'b0, byte_val: 8'h00,       delay_after: 1'b0};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Cycle counter that raises o_term in the N-th enabled cycle (N=0 behaves as 1)
// and restarts itself on terminal count or clear.
module lcd_delay_timer
   import lcd_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_term
);

   logic [CNT_W-1:0] r_cnt;

   assign o_term = i_en && ((i_limit == '0) || (r_cnt >= i_limit - CNT_W'(1)));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear || o_term) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lcd_init_seq.sv
// Power-up sequencer for the SPI LCD: panel hardware reset, fixed command/data
// sequence with settle delays, then a one-cycle o_done to the picture drawer.
module lcd_init_seq
   import lcd_pkg::*;
#(
   parameter int unsigned DELAY      = 2_700_000,
   parameter int unsigned RST_PULSE  = 270,
   parameter logic [7:0]  COLMOD_VAL = 8'h66,
   parameter logic [7:0]  MADCTL_VAL = 8'h00
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_byte_done,
   output logic [7:0] o_byte,
   output logic       o_dc,
   output logic       o_we,
   output logic       o_lcd_rst,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(DELAY);
   localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(RST_PULSE);

   state_e           r_state;
   logic [3:0]       r_index;
   logic             w_tmr_en;
   logic             w_term;
   logic [CNT_W-1:0] w_limit;
   seq_entry_t       w_entry;

   // One timer serves all wait states; it is held cleared everywhere else.
   assign w_tmr_en = (r_state == StHwrstLow) || (r_state == StHwrstWait) ||
                     (r_state == StDelay);
   assign w_limit  = (r_state == StHwrstLow) ? RST_CNT : DELAY_CNT;
   assign w_entry  = seq_entry(r_index, COLMOD_VAL, MADCTL_VAL);

   lcd_delay_timer u_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (!w_tmr_en),
      .i_en    (w_tmr_en),
      .i_limit (w_limit),
      .o_term  (w_term)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_index   <= '0;
         o_byte    <= '0;
         o_dc      <= 1'b0;
         o_we      <= 1'b0;
         o_lcd_rst <= 1'b1;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_we   <= 1'b0;
         o_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_index   <= '0;
                  o_busy    <= 1'b1;
                  o_lcd_rst <= 1'b0;
                  r_state   <= StHwrstLow;
               end
            end
            StHwrstLow: begin
               if (w_term) begin
                  o_lcd_rst <= 1'b1;
                  r_state   <= StHwrstWait;
               end
            end
            StHwrstWait: begin
               if (w_term) r_state <= StLoad;
            end
            StLoad: begin
               o_byte  <= w_entry.byte_val;
               o_dc    <= w_entry.dc;
               o_we    <= 1'b1;
               r_state <= StSend;
            end
            StSend: begin
               if (i_byte_done) begin
                  if (w_entry.delay_after) begin
                     r_state <= StDelay;
                  end else if (r_index == SEQ_LAST) begin
                     r_state <= StDone;
                  end else begin
                     r_index <= r_index + 4'd1;
                     r_state <= StLoad;
                  end
               end
            end
            StDelay: begin
               if (w_term) begin
                  if (r_index == SEQ_LAST) begin
                     r_state <= StDone;
                  end else begin
                     r_index <= r_index + 4'd1;
                     r_state <= StLoad;
                  end
               end
            end
            StDone: begin
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
